if_id_reg: RTL

- IF/ID pipeline register of the 5-stage MIPS core.
- Sits directly downstream of the PC register. Latches the fetched PC and instruction for the decode stage.
- Detects fetch address exceptions (AdEL) and carries the branch-delay-slot flag needed by CP0/EPC logic.
- Supports stall (hold) and flush (bubble insert on exception entry / eret).

---
 rtl/if_id_reg.sv | 58 +++++
 1 files changed

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with fetch AdEL detection, stall and flush.
module if_id_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_TOP   = 32'h0000_4FFC,
  parameter logic [4:0]  EXC_ADEL = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] clr_pc,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic        bd_f,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic [31:0] instr_d,
  output logic [4:0]  exc_d,
  output logic        bd_d,
  output logic        valid_d
);
  logic [31:0] pc_q, pc8_q, instr_q, pc_nxt_d, pc8_nxt_d, instr_nxt_d;
  logic [4:0]  exc_q, exc_nxt_d;
  logic        bd_q, valid_q, bd_nxt_d, valid_nxt_d, adel;
  assign adel = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f > IM_TOP);
  always_comb begin
    pc_nxt_d    = clr ? clr_pc : en ? pc_f : pc_q;
    pc8_nxt_d   = clr ? clr_pc + 32'd8 : en ? pc_f + 32'd8 : pc8_q;
    instr_nxt_d = clr ? 32'd0 : en ? (adel ? 32'd0 : instr_f) : instr_q;
    exc_nxt_d   = clr ? 5'd0 : en ? (adel ? EXC_ADEL : 5'd0) : exc_q;
    bd_nxt_d    = clr ? 1'b0 : en ? bd_f : bd_q;
    valid_nxt_d = clr ? 1'b0 : en ? 1'b1 : valid_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      pc8_q   <= RESET_PC + 32'd8;
      instr_q <= 32'd0;
      exc_q   <= 5'd0;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_nxt_d;
      pc8_q   <= pc8_nxt_d;
      instr_q <= instr_nxt_d;
      exc_q   <= exc_nxt_d;
      bd_q    <= bd_nxt_d;
      valid_q <= valid_nxt_d;
    end
  end
  assign pc_d    = pc_q;
  assign pc8_d   = pc8_q;
  assign instr_d = instr_q;
  assign exc_d   = exc_q;
  assign bd_d    = bd_q;
  assign valid_d = valid_q;
endmodule
